// File: rtl/trace_capture_unit.sv
// Circular trace buffer: captures retired PC (and, with TRACE_ALU_EN, the ALU result),
// stops a programmable number of samples after a PC-match trigger, then reads out oldest-first.
module trace_capture_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [PTR_W:0]    post_count,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_in,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              done,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_alu
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   fill_reg, fill_next;
  logic [PTR_W-1:0] lat_cnt_reg, lat_cnt_next;
  logic [PTR_W-1:0] post_cnt_reg, post_cnt_next;
  logic [PTR_W:0]   popped_reg, popped_next;
  logic             triggered_reg, triggered_next;
  logic             wr_en;

  logic [PTR_W:0]   remaining;
  logic [PTR_W-1:0] rd_idx;
  logic [DATA_W-1:0] pc_mem [DEPTH];

  // Readout walks forward from the oldest entry; wr_ptr/fill are frozen while in DONE.
  assign remaining = fill_reg - popped_reg;
  assign rd_idx    = wr_ptr_reg - fill_reg[PTR_W-1:0] + popped_reg[PTR_W-1:0];
  assign rd_valid  = (state_reg == DONE) && (remaining != '0);
  assign rd_last   = (state_reg == DONE) && (remaining == (PTR_W+1)'(1));
  assign state     = state_reg;
  assign done      = (state_reg == DONE);
  assign triggered = triggered_reg;

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    fill_next      = fill_reg;
    lat_cnt_next   = lat_cnt_reg;
    post_cnt_next  = post_cnt_reg;
    popped_next    = popped_reg;
    triggered_next = triggered_reg;
    wr_en          = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (arm) begin
          state_next     = ARMED;
          wr_ptr_next    = '0;
          fill_next      = '0;
          popped_next    = '0;
          triggered_next = 1'b0;
          // post_count can be at most 2*DEPTH-1, so its MSB alone flags ">= DEPTH"
          lat_cnt_next   = post_count[PTR_W] ? '1 : post_count[PTR_W-1:0];
        end else if (state_reg == DONE && rd_en && rd_valid) begin
          popped_next = popped_reg + 1'b1;
        end
      end
      ARMED, POST: begin
        if (valid_in) begin
          wr_en       = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (fill_reg != FULL) fill_next = fill_reg + 1'b1;
          if (state_reg == ARMED) begin
            if (pc_in == trig_pc) begin
              triggered_next = 1'b1;
              post_cnt_next  = lat_cnt_reg;
              state_next     = (lat_cnt_reg == '0) ? DONE : POST;
            end
          end else begin
            post_cnt_next = post_cnt_reg - 1'b1;
            if (post_cnt_reg == (PTR_W)'(1)) state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      fill_reg      <= '0;
      lat_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      popped_reg    <= '0;
      triggered_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      fill_reg      <= fill_next;
      lat_cnt_reg   <= lat_cnt_next;
      post_cnt_reg  <= post_cnt_next;
      popped_reg    <= popped_next;
      triggered_reg <= triggered_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pc_mem[wr_ptr_reg] <= pc_in;
  end

  assign rd_pc = rd_valid ? pc_mem[rd_idx] : '0;

`ifdef TRACE_ALU_EN
  logic [DATA_W-1:0] alu_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) alu_mem[wr_ptr_reg] <= alu_in;
  end

  assign rd_alu = rd_valid ? alu_mem[rd_idx] : '0;
`else
  logic unused_alu;

  assign unused_alu = ^alu_in;
  assign rd_alu     = '0;
`endif

endmodule

// File: tb/tb_trace_capture_unit.sv
// Bench for trace_capture_unit (DEPTH=8): directed table, corner sequences and random
// traffic checked against a queue-based model of the captured window.
module tb_trace_capture_unit;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic          clk;
  logic          reset;
  logic          arm;
  logic [DW-1:0] trig_pc;
  logic [PW:0]   post_count;
  logic          valid_in;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] alu_in;
  logic [1:0]    state;
  logic          triggered;
  logic          done;
  logic          rd_en;
  logic          rd_valid;
  logic          rd_last;
  logic [DW-1:0] rd_pc;
  logic [DW-1:0] rd_alu;

  trace_capture_unit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .post_count(post_count),
    .valid_in(valid_in), .pc_in(pc_in), .alu_in(alu_in), .state(state),
    .triggered(triggered), .done(done), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_pc(rd_pc), .rd_alu(rd_alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: capture phase, the last DEPTH samples written, and the pending readout list.
  int          m_state;
  int          m_lat;
  int          m_post;
  bit          m_trig;
  logic [31:0] m_hist[$];
  logic [31:0] m_read[$];

  typedef struct {
    bit          v;
    logic [15:0] pc;
    bit          re;
    logic [1:0]  st;
    bit          rv;
    logic [15:0] rp;
    bit          rl;
  } vec_t;
  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sample(input logic [15:0] p, input logic [15:0] al);
    m_hist.push_back({p, al});
    if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit r, input bit a, input bit v, input logic [15:0] p,
                            input logic [15:0] al, input bit re);
    if (r) begin
      m_state = 0; m_trig = 0;
      m_hist.delete(); m_read.delete();
    end else if (a && (m_state == 0 || m_state == 3)) begin
      m_state = 1; m_trig = 0;
      m_hist.delete(); m_read.delete();
      m_lat = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
    end else if (m_state == 1 && v) begin
      push_sample(p, al);
      if (p == trig_pc) begin
        m_trig = 1;
        if (m_lat == 0) begin m_state = 3; m_read = m_hist; end
        else begin m_post = m_lat; m_state = 2; end
      end
    end else if (m_state == 2 && v) begin
      push_sample(p, al);
      m_post--;
      if (m_post == 0) begin m_state = 3; m_read = m_hist; end
    end else if (m_state == 3 && re && m_read.size() > 0) begin
      void'(m_read.pop_front());
    end
  endtask

  task automatic cycle(input bit r, input bit a, input bit v, input logic [15:0] p,
                       input logic [15:0] al, input bit re);
    logic        ev;
    logic [15:0] ep, ea;
    reset = r; arm = a; valid_in = v; pc_in = p; alu_in = al; rd_en = re;
    @(posedge clk);
    model_step(r, a, v, p, al, re);
    #1;
    ev = (m_state == 3) && (m_read.size() > 0);
    ep = ev ? m_read[0][31:16] : 16'h0;
`ifdef TRACE_ALU_EN
    ea = ev ? m_read[0][15:0] : 16'h0;
`else
    ea = 16'h0;
`endif
    check("state", state, m_state);
    check("triggered", triggered, m_trig);
    check("done", done, m_state == 3);
    check("rd_valid", rd_valid, ev);
    check("rd_last", rd_last, ev && m_read.size() == 1);
    check("rd_pc", rd_pc, ep);
    check("rd_alu", rd_alu, ea);
  endtask

  initial begin
    int          n;
    logic [15:0] last_pc;
    logic [15:0] exp_alu;

    for (int i = 0; i <= 10; i++) begin
      tbl[i].v  = 1'b1;
      tbl[i].pc = 16'(2 * i);
      tbl[i].re = 1'b0;
      tbl[i].st = (2 * i < 16'h10) ? 2'd1 : ((2 * i == 16'h14) ? 2'd3 : 2'd2);
      tbl[i].rv = (i == 10);
      tbl[i].rp = (i == 10) ? 16'h0006 : 16'h0000;
      tbl[i].rl = 1'b0;
    end
    for (int k = 1; k <= 8; k++) begin
      tbl[10+k].v  = 1'b0;
      tbl[10+k].pc = 16'h0;
      tbl[10+k].re = 1'b1;
      tbl[10+k].st = 2'd3;
      tbl[10+k].rv = (k < 8);
      tbl[10+k].rp = (k < 8) ? 16'(6 + 2 * k) : 16'h0;
      tbl[10+k].rl = (k == 7);
    end

    m_state = 0; m_trig = 0; m_lat = 0; m_post = 0;
    reset = 1; arm = 0; valid_in = 0; pc_in = 0; alu_in = 0; rd_en = 0;
    trig_pc = 16'h0010; post_count = 4'd2;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("reset_state", state, 0);
    check("reset_rd_valid", rd_valid, 0);

    // Wrap and trigger: pc 0x00..0x14, alu = pc+1
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      cycle(0, 0, tbl[i].v, tbl[i].pc, tbl[i].pc + 16'h1, tbl[i].re);
`ifdef TRACE_ALU_EN
      exp_alu = tbl[i].rv ? tbl[i].rp + 16'h1 : 16'h0;
`else
      exp_alu = 16'h0;
`endif
      check($sformatf("tbl%0d_state", i), state, tbl[i].st);
      check($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].rv);
      check($sformatf("tbl%0d_rd_pc", i), rd_pc, tbl[i].rp);
      check($sformatf("tbl%0d_rd_last", i), rd_last, tbl[i].rl);
      check($sformatf("tbl%0d_rd_alu", i), rd_alu, exp_alu);
    end

    // Immediate trigger with post_count=0
    trig_pc = 16'h0000; post_count = 4'd0;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 16'h0000, 16'h0001, 0);
    check("imm_state", state, 3);
    check("imm_rd_valid", rd_valid, 1);
    check("imm_rd_last", rd_last, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("imm_after_pop_valid", rd_valid, 0);

    // Gaps in valid_in after the trigger
    trig_pc = 16'h0020; post_count = 4'd3;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 16'h001E, 16'h0100, 0);
    cycle(0, 0, 1, 16'h0020, 16'h0101, 0);
    check("gap_trig_state", state, 2);
    cycle(0, 0, 1, 16'h0022, 16'h0102, 0);
    cycle(0, 0, 0, 16'h0020, 16'h0103, 0);
    cycle(0, 0, 1, 16'h0024, 16'h0104, 0);
    cycle(0, 0, 0, 16'h0020, 16'h0105, 0);
    check("gap_pre_last_state", state, 2);
    cycle(0, 0, 1, 16'h0026, 16'h0106, 0);
    check("gap_done_state", state, 3);
    n = 0; last_pc = 16'h0;
    while (rd_valid && n < 10) begin
      last_pc = rd_pc;
      cycle(0, 0, 0, 0, 0, 1);
      n++;
    end
    check("gap_entries", n, 5);
    check("gap_last_pc", last_pc, 16'h0026);

    // Reset held two cycles during POST, then arm with a clamped post_count
    trig_pc = 16'h0040; post_count = 4'd15;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 16'h0040, 16'h0, 0);
    check("rst_pre_state", state, 2);
    cycle(1, 0, 1, 16'h0042, 16'h0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_state", state, 0);
    check("rst_triggered", triggered, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_pc", rd_pc, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("rst_arm_state", state, 1);

    // Clamp: 3 pre samples, trigger, 7 post samples
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 16'(16'h003A + 2 * i), 16'(i), 0);
    cycle(0, 0, 1, 16'h0040, 16'h0040, 0);
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 1, 16'(16'h0040 + 2 * i), 16'(i), 0);
      if (i == 6) check("clamp_post6_state", state, 2);
    end
    check("clamp_done_state", state, 3);
    check("clamp_oldest_pc", rd_pc, 16'h0040);

    // Re-arm in DONE with a simultaneous pop
    cycle(0, 1, 0, 0, 0, 1);
    check("rearm_state", state, 1);
    check("rearm_rd_valid", rd_valid, 0);
    check("rearm_triggered", triggered, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) trig_pc = 16'(2 * $urandom_range(0, 15));
      post_count = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) != 0, 16'(2 * $urandom_range(0, 15)),
            16'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
